dmem_responder: RTL and testbench

Word-addressed data memory that answers load/store requests from the CPU datapath over a valid/ready request channel, with a fixed, parameterised access latency. It takes the datapath's ALU byte address and store data, and returns load data and a one-cycle response strobe. It is the memory-side counterpart to the datapath's data port and is the first step toward a stalling (multi-cycle) memory system. A combinational debug read port lets the board/testbench inspect memory, in the same way registers are inspected.

---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a valid/ready request channel.
// Each accepted request commits a fixed Latency edges later and answers with a one-cycle strobe.
module dmem_responder #(
    parameter int AddrWidth = 8,
    parameter int Latency   = 2
) (
    input  logic                 CLK,
    input  logic                 ResetN,
    input  logic                 Req,
    input  logic                 MemWrite,
    input  logic [31:0]          Addr,
    input  logic [31:0]          WriteData,
    output logic                 Ready,
    output logic                 RespValid,
    output logic [31:0]          ReadData,
    output logic                 AddrErr,
    input  logic [AddrWidth-1:0] DbgAddr,
    output logic [31:0]          DbgData
);

    localparam int         Depth   = 1 << AddrWidth;
    localparam logic [3:0] CntInit = 4'(Latency - 1);

    if (Latency < 1 || Latency > 15) begin : g_latency_check
        $error("dmem_responder: Latency must be in 1..15");
    end

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic                  r_resp_vld;
    logic                  r_addr_err;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [Depth];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_illegal;
    logic [AddrWidth-1:0]  w_idx;

    assign w_accept  = (r_state == IDLE) && Req;
    assign w_commit  = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_idx     = r_addr[AddrWidth+1:2];
    assign w_illegal = (r_addr[1:0] != 2'b00) || (|r_addr[31:AddrWidth+2]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (Req) w_state_nxt = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_resp_vld <= 1'b0;
            r_addr_err <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_resp_vld <= w_commit;
            r_addr_err <= w_commit && w_illegal;
            if (w_accept) begin
                r_cnt <= CntInit;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Stores leave ReadData alone; loads and rejected requests overwrite it.
            if (w_commit && (!r_we || w_illegal)) begin
                r_rdata <= w_illegal ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_addr  <= Addr;
            r_wdata <= WriteData;
            r_we    <= MemWrite;
        end
    end

    // Gated by r_state, so an async reset during WAIT cancels the pending write.
    always_ff @(posedge CLK) begin
        if (w_commit && r_we && !w_illegal) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign Ready     = (r_state == IDLE);
    assign RespValid = r_resp_vld;
    assign AddrErr   = r_addr_err;
    assign ReadData  = r_rdata;
    assign DbgData   = r_mem[DbgAddr];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a Latency=2 instance for most scenarios
// and a Latency=1 instance for the store-then-load case.
module tb_dmem_responder;

    logic        CLK;
    logic        ResetN;

    logic        Req, MemWrite;
    logic [31:0] Addr, WriteData;
    logic        Ready, RespValid, AddrErr;
    logic [31:0] ReadData, DbgData;
    logic [7:0]  DbgAddr;

    logic        Req1, MemWrite1;
    logic [31:0] Addr1, WriteData1;
    logic        Ready1, RespValid1, AddrErr1;
    logic [31:0] ReadData1, DbgData1;
    logic [7:0]  DbgAddr1;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.AddrWidth(8), .Latency(2)) u_dut (
        .CLK(CLK), .ResetN(ResetN), .Req(Req), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .Ready(Ready), .RespValid(RespValid),
        .ReadData(ReadData), .AddrErr(AddrErr), .DbgAddr(DbgAddr), .DbgData(DbgData)
    );

    dmem_responder #(.AddrWidth(8), .Latency(1)) u_dut_l1 (
        .CLK(CLK), .ResetN(ResetN), .Req(Req1), .MemWrite(MemWrite1),
        .Addr(Addr1), .WriteData(WriteData1), .Ready(Ready1), .RespValid(RespValid1),
        .ReadData(ReadData1), .AddrErr(AddrErr1), .DbgAddr(DbgAddr1), .DbgData(DbgData1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request on the Latency=2 instance; returns edges from acceptance to strobe (-1 on timeout).
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
        Req = 1'b1; MemWrite = we; Addr = a; WriteData = wd;
        tick();
        Req = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1 || 1) begin end
            tick();
            if (RespValid) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int n_acc, n_resp;
    int acc_cyc [3];
    logic [31:0] burst_data [3];

    initial begin
        Req = 0; MemWrite = 0; Addr = 0; WriteData = 0; DbgAddr = 0;
        Req1 = 0; MemWrite1 = 0; Addr1 = 0; WriteData1 = 0; DbgAddr1 = 0;
        burst_data[0] = 32'hA0A0_0001;
        burst_data[1] = 32'hB0B0_0002;
        burst_data[2] = 32'hC0C0_0003;
        ResetN = 1'b0;
        #2;
        tick();
        check("rst_ready", {31'd0, Ready}, 32'd1);
        check("rst_respvalid", {31'd0, RespValid}, 32'd0);
        check("rst_addrerr", {31'd0, AddrErr}, 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        tick();
        ResetN = 1'b1;
        tick();

        // Store 0xDEADBEEF to 0x10, cycle by cycle.
        Req = 1; MemWrite = 1; Addr = 32'h10; WriteData = 32'hDEADBEEF;
        check("st_ready_before", {31'd0, Ready}, 32'd1);
        tick();
        Req = 0; MemWrite = 0; Addr = 0; WriteData = 0;
        check("st_ready_c1", {31'd0, Ready}, 32'd0);
        check("st_resp_c1", {31'd0, RespValid}, 32'd0);
        tick();
        check("st_ready_c2", {31'd0, Ready}, 32'd0);
        check("st_resp_c2", {31'd0, RespValid}, 32'd0);
        tick();
        check("st_resp", {31'd0, RespValid}, 32'd1);
        check("st_addrerr", {31'd0, AddrErr}, 32'd0);
        check("st_ready_resp", {31'd0, Ready}, 32'd1);
        DbgAddr = 8'd4;
        #1;
        check("st_dbg", DbgData, 32'hDEADBEEF);

        // Back-to-back load from 0x10 presented in the response cycle.
        issue(1'b0, 32'h10, 32'h0, lat);
        check("ld_latency", lat, 32'd2);
        check("ld_data", ReadData, 32'hDEADBEEF);
        check("ld_addrerr", {31'd0, AddrErr}, 32'd0);
        tick();
        check("ld_resp_clears", {31'd0, RespValid}, 32'd0);
        tick();
        check("ld_data_hold", ReadData, 32'hDEADBEEF);

        // Misaligned store, legal reload, out-of-range load.
        issue(1'b1, 32'h12, 32'h12345678, lat);
        check("mis_latency", lat, 32'd2);
        check("mis_addrerr", {31'd0, AddrErr}, 32'd1);
        check("mis_readdata", ReadData, 32'd0);
        DbgAddr = 8'd4;
        #1;
        check("mis_mem4", DbgData, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 32'h0, lat);
        check("reload_data", ReadData, 32'hDEADBEEF);
        issue(1'b0, 32'h400, 32'h0, lat);
        check("oor_latency", lat, 32'd2);
        check("oor_addrerr", {31'd0, AddrErr}, 32'd1);
        check("oor_readdata", ReadData, 32'd0);
        DbgAddr = 8'd4;
        #1;
        check("oor_mem4", DbgData, 32'hDEADBEEF);

        // Req held high for three stores to 0x30/0x34/0x38.
        tick();
        n_acc = 0;
        n_resp = 0;
        Req = 1; MemWrite = 1; Addr = 32'h30; WriteData = burst_data[0];
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (Req && Ready && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                tick();
                if (n_acc < 3) begin
                    Addr = 32'h30 + 32'(4 * n_acc);
                    WriteData = burst_data[n_acc];
                end else begin
                    Req = 0; MemWrite = 0; Addr = 0; WriteData = 0;
                end
            end else begin
                tick();
            end
            if (RespValid) n_resp++;
        end
        check("burst_accepts", n_acc, 32'd3);
        check("burst_resps", n_resp, 32'd3);
        check("burst_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
        check("burst_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
        for (int k = 0; k < 3; k++) begin
            DbgAddr = 8'(12 + k);
            #1;
            check($sformatf("burst_mem%0d", 12 + k), DbgData, burst_data[k]);
        end

        // Reset while a store to 0x20 is pending.
        issue(1'b1, 32'h20, 32'h11111111, lat);
        check("pre_rst_store", lat, 32'd2);
        Req = 1; MemWrite = 1; Addr = 32'h20; WriteData = 32'h22222222;
        tick();
        Req = 0; MemWrite = 0; Addr = 0; WriteData = 0;
        #2 ResetN = 1'b0;
        #3 ResetN = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (RespValid) n_resp++;
        end
        check("rst_wait_noresp", n_resp, 32'd0);
        check("rst_wait_ready", {31'd0, Ready}, 32'd1);
        DbgAddr = 8'd8;
        #1;
        check("rst_wait_mem8", DbgData, 32'h11111111);
        issue(1'b0, 32'h20, 32'h0, lat);
        check("post_rst_latency", lat, 32'd2);
        check("post_rst_data", ReadData, 32'h11111111);

        // Latency=1 instance: store then immediately load the same word.
        Req1 = 1; MemWrite1 = 1; Addr1 = 32'h40; WriteData1 = 32'hCAFEF00D;
        tick();
        Req1 = 0; MemWrite1 = 0;
        check("l1_ready_wait", {31'd0, Ready1}, 32'd0);
        tick();
        check("l1_st_resp", {31'd0, RespValid1}, 32'd1);
        check("l1_ready_resp", {31'd0, Ready1}, 32'd1);
        Req1 = 1; MemWrite1 = 0; Addr1 = 32'h40;
        tick();
        Req1 = 0;
        check("l1_ld_noresp_yet", {31'd0, RespValid1}, 32'd0);
        tick();
        check("l1_ld_resp", {31'd0, RespValid1}, 32'd1);
        check("l1_ld_data", ReadData1, 32'hCAFEF00D);
        DbgAddr1 = 8'd16;
        #1;
        check("l1_dbg", DbgData1, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
